// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio
//   Memory-mapped 8N1 UART transmitter on the CPU data bus. A write to TXDATA
//   queues one byte in a small FIFO. The FSM then sends queued bytes LSB first
//   on tx_o, with no gap between frames. STATUS reports the FIFO/FSM state and
//   a sticky overflow flag. Writing STATUS with bit 3 set clears that flag.
//
//   Ports
//     clk_i   system clock; all logic runs on the rising edge
//     rst_i   synchronous active-high reset
//     addr_i  CPU word address (TXDATA = BASE_ADDR, STATUS = BASE_ADDR+1)
//     data_i  CPU write data (only [7:0] used for TXDATA, [3] for STATUS)
//     we_i    write enable, sampled at the rising edge
//     data_o  registered read data, one cycle after the address is presented
//     sel_o   combinational decode: addr_i hits TXDATA or STATUS
//     tx_o    serial output, idle high
//
//   STATUS: [0] full [1] empty [2] busy [3] overflow [7:4] FIFO count
//
//   Bus handshake: there is no stall. A write with we_i high is always
//   consumed at that edge. A read is always answered on data_o after the edge.
module uart_tx_mmio #(
    parameter logic [15:0] BASE_ADDR      = 16'hFF00,
    parameter logic [15:0] CLK_DIV        = 16'd104,
    parameter int          FIFO_DEPTH_LOG = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [15:0] addr_i,
    input  logic [15:0] data_i,
    input  logic        we_i,
    output logic [15:0] data_o,
    output logic        sel_o,
    output logic        tx_o
);

    localparam int DEPTH = 2 ** FIFO_DEPTH_LOG;
    localparam logic [FIFO_DEPTH_LOG-1:0] PTR_ONE  = FIFO_DEPTH_LOG'(1);
    localparam logic [FIFO_DEPTH_LOG:0]   CNT_ONE  = (FIFO_DEPTH_LOG+1)'(1);
    localparam logic [FIFO_DEPTH_LOG:0]   CNT_FULL = (FIFO_DEPTH_LOG+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    // Address decode
    logic addr_txdata, addr_status;
    assign addr_txdata = (addr_i == BASE_ADDR);
    assign addr_status = (addr_i == BASE_ADDR + 16'd1);
    assign sel_o       = addr_txdata | addr_status;

    // The upper write byte has no function.
    logic unused_data_hi;
    assign unused_data_hi = ^data_i[15:8];

    // FIFO
    logic [7:0]                fifo_mem [DEPTH];
    logic [FIFO_DEPTH_LOG-1:0] wr_ptr_q, rd_ptr_q;
    logic [FIFO_DEPTH_LOG:0]   count_q;
    logic                      overflow_q;
    logic                      fifo_full, fifo_empty;
    logic                      push, pop, ovf_set, ovf_clr;

    assign fifo_full  = (count_q == CNT_FULL);
    assign fifo_empty = (count_q == '0);

    // A pop in the same cycle frees a slot, so a push into a full FIFO is still taken.
    assign push    = we_i & addr_txdata & (~fifo_full | pop);
    assign ovf_set = we_i & addr_txdata & fifo_full & ~pop;
    assign ovf_clr = we_i & addr_status & data_i[3];

    // Transmitter FSM and datapath
    state_t      state_q, state_d;
    logic [15:0] baud_q, baud_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shift_q, shift_d;
    logic        tx_q, tx_d;
    logic        baud_done, advance;

    assign baud_done = (baud_q == '0);

    // State register (plus the datapath registers moved by the FSM)
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            baud_q    <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = START;
                end
            end
            START: begin
                if (baud_done) state_d = DATA;
            end
            DATA: begin
                if (baud_done && bit_idx_q == 3'd7) state_d = STOP;
            end
            STOP: begin
                if (baud_done) begin
                    // Chain straight into the next start bit when more data is queued.
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output/datapath logic. Every bit period reloads the baud counter and drives the next tx level.
    always_comb begin
        tx_d      = tx_q;
        bit_idx_d = bit_idx_q;
        baud_d    = baud_q;
        shift_d   = shift_q;
        // In IDLE the counter is parked at 0, so only a pop starts a frame.
        advance   = (state_q == IDLE) ? pop : baud_done;
        if (advance) begin
            baud_d = CLK_DIV - 16'd1;
            case (state_d)
                START: begin
                    shift_d = fifo_mem[rd_ptr_q];
                    tx_d    = 1'b0;
                end
                DATA: begin
                    bit_idx_d = (state_q == START) ? 3'd0 : bit_idx_q + 3'd1;
                    tx_d      = shift_q[bit_idx_d];
                end
                default: begin
                    // STOP bit, or back to IDLE with the line high
                    tx_d = 1'b1;
                    if (state_d == IDLE) baud_d = '0;
                end
            endcase
        end else if (state_q != IDLE) begin
            baud_d = baud_q - 16'd1;
        end
    end

    assign tx_o = tx_q;

    // FIFO storage and bookkeeping
    always_ff @(posedge clk_i) begin
        if (push && !rst_i) fifo_mem[wr_ptr_q] <= data_i[7:0];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
            if (push && !pop)      count_q <= count_q + CNT_ONE;
            else if (pop && !push) count_q <= count_q - CNT_ONE;
            // A drop in the same cycle as a clear wins.
            if (ovf_set)      overflow_q <= 1'b1;
            else if (ovf_clr) overflow_q <= 1'b0;
        end
    end

    // Registered read port; reflects the state before this edge's updates.
    logic [15:0] status;
    assign status = {8'h00, 4'(count_q), overflow_q, (state_q != IDLE), fifo_empty, fifo_full};

    always_ff @(posedge clk_i) begin
        if (rst_i)            data_o <= '0;
        else if (addr_status) data_o <= status;
        else                  data_o <= '0;
    end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Bench for uart_tx_mmio (CLK_DIV=4, 4-entry FIFO). A frame-level model predicts tx_o, data_o and sel_o.
// That model is a byte queue plus a position counter within the current 10-bit frame.
// Directed sections pin literal values. A randomized section exercises the rest.
module tb_uart_tx_mmio;

    localparam logic [15:0] BASE  = 16'hFF00;
    localparam int          DIV   = 4;
    localparam int          DEPTH = 4;

    // Clock / reset
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] addr = '0;
    logic [15:0] wdata = '0;
    logic        we = 1'b0;
    logic [15:0] data_o;
    logic        sel_o;
    logic        tx_o;

    always #5 clk = ~clk;

    uart_tx_mmio #(
        .BASE_ADDR(BASE),
        .CLK_DIV(16'(DIV)),
        .FIFO_DEPTH_LOG(2)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .addr_i(addr),
        .data_i(wdata),
        .we_i(we),
        .data_o(data_o),
        .sel_o(sel_o),
        .tx_o(tx_o)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Driver: every call occupies one bus cycle, applied at the falling edge.
    task automatic drive(input logic [15:0] a, input logic [15:0] d, input logic w, input logic r);
        @(negedge clk);
        rst   = r;
        addr  = a;
        wdata = d;
        we    = w;
    endtask

    task automatic idle();
        drive(16'h0000, 16'h0000, 1'b0, 1'b0);
    endtask

    // Scoreboard model: queued bytes plus the frame currently on the wire
    logic [7:0]  exp_q[$];
    bit          m_valid = 0;
    bit          m_active = 0;
    logic [7:0]  m_byte = '0;
    int          m_pos = 0;
    bit          m_ovf = 0;
    logic [15:0] m_data = '0;
    int          m_cnt;
    logic [15:0] m_status;
    bit          m_pop, m_set;

    // Line level at frame position: start bit, 8 data bits LSB first, stop bit
    function automatic logic m_tx();
        int slot;
        if (!m_active) return 1'b1;
        slot = m_pos / DIV;
        if (slot == 0) return 1'b0;
        if (slot == 9) return 1'b1;
        return m_byte[slot-1];
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            exp_q.delete();
            m_active = 0;
            m_pos    = 0;
            m_ovf    = 0;
            m_data   = '0;
            m_valid  = 1;
        end else if (m_valid) begin
            m_cnt    = exp_q.size();
            m_status = {8'h00, 4'(m_cnt), m_ovf, m_active, (m_cnt == 0), (m_cnt == DEPTH)};
            m_data   = (addr == BASE + 16'd1) ? m_status : 16'h0000;
            m_pop    = 0;
            if (!m_active) begin
                if (m_cnt > 0) m_pop = 1;
            end else if (m_pos == 10 * DIV - 1) begin
                if (m_cnt > 0) m_pop = 1;
                else m_active = 0;
            end else begin
                m_pos++;
            end
            m_set = 0;
            if (we && addr == BASE) begin
                if (m_cnt < DEPTH || m_pop) exp_q.push_back(wdata[7:0]);
                else m_set = 1;
            end
            if (m_set) m_ovf = 1;
            else if (we && addr == BASE + 16'd1 && wdata[3]) m_ovf = 0;
            if (m_pop) begin
                m_byte   = exp_q.pop_front();
                m_active = 1;
                m_pos    = 0;
            end
        end
    end

    // Per-cycle comparison against the model
    always @(posedge clk) begin
        #1;
        if (m_valid) begin
            check("tx_o", {15'h0, tx_o}, {15'h0, m_tx()});
            check("data_o", data_o, m_data);
            check("sel_o", {15'h0, sel_o}, {15'h0, (addr == BASE) || (addr == BASE + 16'd1)});
        end
    end

    task automatic wait_drain();
        for (int i = 0; i < 2000 && (m_active || exp_q.size() != 0); i++) begin
            @(posedge clk);
            #2;
        end
    endtask

    int bit_lit[10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};   // 8'hA5 frame

    initial begin
        int r;
        // Reset held for two edges
        repeat (2) @(posedge clk);
        #2;
        check("reset_tx", {15'h0, tx_o}, 16'h0001);
        check("reset_data", data_o, 16'h0000);
        drive(16'h0000, 16'h0000, 1'b0, 1'b0);
        drive(BASE + 16'd1, 16'h0000, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        check("reset_status", data_o, 16'h0002);

        // Single frame of 8'hA5; the high write byte is ignored
        drive(BASE, 16'h12A5, 1'b1, 1'b0);
        @(posedge clk);
        idle();
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #2;
            check("a5_wave", {15'h0, tx_o}, 16'(bit_lit[(k-1)/DIV]));
        end
        idle();
        @(posedge clk);
        #2;
        check("a5_line_idle", {15'h0, tx_o}, 16'h0001);
        drive(BASE + 16'd1, 16'h0000, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        check("a5_not_busy", data_o, 16'h0002);

        // Five back-to-back writes (one overlapping pop), then a sixth that overflows
        for (int i = 0; i < 5; i++) drive(BASE, 16'($urandom), 1'b1, 1'b0);
        drive(BASE + 16'd1, 16'h0000, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        check("burst5_status", data_o, 16'h0045);
        drive(BASE, 16'h00EE, 1'b1, 1'b0);
        drive(BASE + 16'd1, 16'h0000, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        check("overflow_status", data_o, 16'h004D);
        drive(BASE + 16'd1, 16'h0008, 1'b1, 1'b0);
        drive(BASE + 16'd1, 16'h0000, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        check("ovf_cleared", data_o, 16'h0045);
        idle();
        wait_drain();
        drive(BASE + 16'd1, 16'h0000, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        check("drained_status", data_o, 16'h0002);

        // Reset during data bit 3 of 8'h35 with a second byte queued
        drive(BASE, 16'h0035, 1'b1, 1'b0);
        drive(BASE, 16'h005A, 1'b1, 1'b0);
        for (int j = 2; j <= 17; j++) idle();
        @(posedge clk);
        #2;
        check("bit3_level", {15'h0, tx_o}, 16'h0000);
        drive(16'h0000, 16'h0000, 1'b0, 1'b1);
        @(posedge clk);
        #2;
        check("abort_tx", {15'h0, tx_o}, 16'h0001);
        drive(BASE + 16'd1, 16'h0000, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        check("abort_status", data_o, 16'h0002);
        for (int j = 0; j < 40; j++) begin
            idle();
            @(posedge clk);
            #2;
            check("abort_quiet", {15'h0, tx_o}, 16'h0001);
        end

        // Read decode
        drive(BASE, 16'h0000, 1'b0, 1'b0);
        #1;
        check("sel_txdata", {15'h0, sel_o}, 16'h0001);
        @(posedge clk);
        #2;
        check("read_txdata", data_o, 16'h0000);
        drive(BASE + 16'd1, 16'h0000, 1'b0, 1'b0);
        #1;
        check("sel_status", {15'h0, sel_o}, 16'h0001);
        @(posedge clk);
        #2;
        check("read_status", data_o, 16'h0002);
        drive(16'hFEFF, 16'h0000, 1'b0, 1'b0);
        #1;
        check("sel_feff", {15'h0, sel_o}, 16'h0000);
        @(posedge clk);
        #2;
        check("read_feff", data_o, 16'h0000);
        drive(16'hFF02, 16'h00FF, 1'b1, 1'b0);
        #1;
        check("sel_ff02", {15'h0, sel_o}, 16'h0000);

        // Randomized traffic
        for (int c = 0; c < 4000; c++) begin
            r = $urandom_range(0, 999);
            if (r < 5) begin
                drive(16'($urandom), 16'($urandom), 1'($urandom), 1'b1);
            end else if (r < 8) begin
                for (int b = 0; b < 6; b++) drive(BASE, 16'($urandom), 1'b1, 1'b0);
            end else if (r < 23) begin
                drive(BASE, 16'($urandom), 1'b1, 1'b0);
            end else if (r < 45) begin
                drive(BASE + 16'd1, 16'($urandom), 1'b1, 1'b0);
            end else if (r < 60) begin
                case ($urandom_range(0, 2))
                    0:       drive(16'hFEFF, 16'($urandom), 1'b1, 1'b0);
                    1:       drive(16'hFF02, 16'($urandom), 1'b1, 1'b0);
                    default: drive(16'($urandom), 16'($urandom), 1'b1, 1'b0);
                endcase
            end else if (r < 400) begin
                drive(BASE + 16'd1, 16'($urandom), 1'b0, 1'b0);
            end else if (r < 500) begin
                drive(BASE, 16'($urandom), 1'b0, 1'b0);
            end else begin
                drive(16'($urandom), 16'($urandom), 1'b0, 1'b0);
            end
        end
        idle();
        wait_drain();
        repeat (3) idle();
        @(posedge clk);
        #2;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
